// File: rtl/cfg_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// Holds the loader state encoding and the default chain word width.
package cfg_pkg;

  localparam int CFG_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } state_t;

endpackage

// File: rtl/config_loader.sv
// Streams configuration words into a shift-register chain (LOAD) or recirculates
// them out non-destructively (READ), with a handshake per shifted word.
module config_loader
  import cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = CFG_DEFAULT_WIDTH,
  parameter int CHAIN_WORDS  = 8
) (
  input  logic                    config_clk,
  input  logic                    config_rst_n,
  input  logic                    start_load,
  input  logic                    start_read,
  input  logic                    abort,
  input  logic [CONFIG_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [CONFIG_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    config_en,
  output logic [CONFIG_WIDTH-1:0] config_in,
  input  logic [CONFIG_WIDTH-1:0] chain_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int CNT_W = $clog2(CHAIN_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_WORDS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic             r_done;
  logic             w_doneNext;
  logic             r_err;
  logic             w_errNext;
  logic             w_handshake;

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_countNext;
      r_done  <= w_doneNext;
      r_err   <= w_errNext;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_countNext = r_count;
    w_doneNext  = 1'b0;
    w_errNext   = r_err;
    w_handshake = 1'b0;
    in_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    config_en   = 1'b0;
    config_in   = '0;

    case (r_state)
      ST_IDLE: begin
        // Simultaneous requests are ambiguous, so neither is honoured.
        if (start_load && start_read) begin
          w_errNext = 1'b1;
        end else if (start_load) begin
          w_nextState = ST_LOAD;
          w_countNext = '0;
          w_errNext   = 1'b0;
        end else if (start_read) begin
          w_nextState = ST_READ;
          w_countNext = '0;
          w_errNext   = 1'b0;
        end
      end
      ST_LOAD: begin
        in_ready    = !abort;
        config_in   = in_data;
        config_en   = in_valid && !abort;
        w_handshake = in_valid && !abort;
      end
      ST_READ: begin
        // Feeding the tail back into the head keeps the chain contents intact.
        rd_valid    = !abort;
        rd_data     = chain_out;
        config_in   = chain_out;
        config_en   = rd_ready && !abort;
        w_handshake = rd_ready && !abort;
      end
      default: begin
        w_nextState = ST_IDLE;
        w_countNext = '0;
      end
    endcase

    if (r_state != ST_IDLE) begin
      if (start_load || start_read) begin
        w_errNext = 1'b1;
      end
      if (abort) begin
        w_nextState = ST_IDLE;
        w_countNext = '0;
      end else if (w_handshake) begin
        if (r_count == LAST_IDX) begin
          w_nextState = ST_IDLE;
          w_countNext = '0;
          w_doneNext  = 1'b1;
        end else begin
          w_countNext = r_count + CNT_W'(1);
        end
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_config_loader.sv
// Directed self-checking bench for config_loader with a behavioural model of
// the 8-word configuration chain hanging off config_en/config_in.
module tb_config_loader;
  import cfg_pkg::*;

  localparam int W = 8;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rstN;
  logic         startLoad;
  logic         startRead;
  logic         abortReq;
  logic [W-1:0] inData;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] rdData;
  logic         rdValid;
  logic         rdReady;
  logic         configEn;
  logic [W-1:0] configIn;
  logic [W-1:0] chainOut;
  logic         busy;
  logic         done;
  logic         err;

  int totalCount = 0;
  int badCount   = 0;
  int enCount    = 0;
  int doneCount  = 0;
  int enMark;
  int doneMark;

  logic [W-1:0] chainModel [N] = '{default: '0};

  always #5 clk = ~clk;

  config_loader #(.CONFIG_WIDTH(W), .CHAIN_WORDS(N)) dut (
    .config_clk  (clk),
    .config_rst_n(rstN),
    .start_load  (startLoad),
    .start_read  (startRead),
    .abort       (abortReq),
    .in_data     (inData),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .rd_data     (rdData),
    .rd_valid    (rdValid),
    .rd_ready    (rdReady),
    .config_en   (configEn),
    .config_in   (configIn),
    .chain_out   (chainOut),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Chain model: head at index 0, far (config_out) end at index N-1.
  always @(posedge clk) begin
    if (configEn === 1'b1) begin
      for (int i = N - 1; i > 0; i--) chainModel[i] <= chainModel[i-1];
      chainModel[0] <= configIn;
    end
  end
  assign chainOut = chainModel[N-1];

  always @(posedge clk) begin
    if (configEn === 1'b1) enCount++;
    if (done === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) else begin
      badCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic isLoad);
    startLoad = isLoad;
    startRead = !isLoad;
    tick();
    startLoad = 1'b0;
    startRead = 1'b0;
    checkOutput("start_busy", busy, 1);
  endtask

  task automatic loadWords(input logic [W-1:0] first);
    for (int i = 0; i < N; i++) begin
      inValid = 1'b1;
      inData  = first + W'(i);
      #1;
      checkOutput("load_en", configEn, 1);
      checkOutput("load_in", configIn, first + W'(i));
      tick();
      if (i < N - 1) checkOutput("load_nodone", done, 0);
    end
    inValid = 1'b0;
    checkOutput("load_done", done, 1);
    checkOutput("load_idle", busy, 0);
    tick();
    checkOutput("load_done_once", done, 0);
  endtask

  task automatic readWords(input logic [W-1:0] first);
    doneMark = doneCount;
    applyStimulus(1'b0);
    rdReady = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      checkOutput("rd_valid", rdValid, 1);
      checkOutput("rd_data", rdData, first + W'(i));
      checkOutput("rd_en", configEn, 1);
      tick();
    end
    rdReady = 1'b0;
    checkOutput("rd_done", done, 1);
    tick();
    checkOutput("rd_done_once", doneCount - doneMark, 1);
    checkOutput("rd_far_intact", chainModel[N-1], first);
    checkOutput("rd_head_intact", chainModel[0], first + W'(N - 1));
  endtask

  initial begin
    rstN = 1'b0; startLoad = 1'b0; startRead = 1'b0; abortReq = 1'b0;
    inData = '0; inValid = 1'b0; rdReady = 1'b0;

    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_en", configEn, 0);
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_rd_valid", rdValid, 0);
    checkOutput("rst_config_in", configIn, 0);
    #10 rstN = 1'b1;
    tick();

    $display("[TB] full load 0x01..0x08");
    enMark = enCount;
    applyStimulus(1'b1);
    checkOutput("load_in_ready", inReady, 1);
    loadWords(8'h01);
    checkOutput("load_en_cycles", enCount - enMark, 8);
    checkOutput("load_far_end", chainModel[N-1], 8'h01);

    $display("[TB] readback twice");
    readWords(8'h01);
    readWords(8'h01);

    $display("[TB] abort in IDLE");
    abortReq = 1'b1;
    tick();
    abortReq = 1'b0;
    checkOutput("idle_abort_busy", busy, 0);
    checkOutput("idle_abort_err", err, 0);
    checkOutput("idle_abort_done", done, 0);

    $display("[TB] toggling in_valid");
    enMark = enCount;
    applyStimulus(1'b1);
    for (int j = 0; j < 2 * N - 1; j++) begin
      inValid = (j % 2 == 0);
      inData  = 8'h10 + W'(j / 2);
      #1;
      checkOutput("tog_en", configEn, inValid);
      tick();
      if (j < 2 * N - 2) checkOutput("tog_busy", busy, 1);
    end
    inValid = 1'b0;
    checkOutput("tog_done", done, 1);
    checkOutput("tog_en_cycles", enCount - enMark, 8);
    tick();
    checkOutput("tog_far_end", chainModel[N-1], 8'h10);

    $display("[TB] abort after three words");
    enMark = enCount;
    doneMark = doneCount;
    applyStimulus(1'b1);
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1;
      inData  = 8'h41 + W'(i);
      tick();
    end
    abortReq = 1'b1;
    #1;
    checkOutput("abort_in_ready", inReady, 0);
    checkOutput("abort_en", configEn, 0);
    tick();
    abortReq = 1'b0;
    inValid  = 1'b0;
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_en_cycles", enCount - enMark, 3);
    tick();
    checkOutput("abort_done_count", doneCount - doneMark, 0);
    applyStimulus(1'b1);
    checkOutput("restart_count", dut.r_count, 0);
    loadWords(8'h21);
    checkOutput("restart_far_end", chainModel[N-1], 8'h21);

    $display("[TB] start conflicts and err");
    startLoad = 1'b1;
    startRead = 1'b1;
    tick();
    startLoad = 1'b0;
    startRead = 1'b0;
    checkOutput("both_err", err, 1);
    checkOutput("both_idle", busy, 0);
    applyStimulus(1'b1);
    checkOutput("clean_start_err", err, 0);
    startRead = 1'b1;
    tick();
    startRead = 1'b0;
    checkOutput("busy_start_err", err, 1);
    checkOutput("busy_stays_load", inReady, 1);
    checkOutput("busy_no_read", rdValid, 0);
    loadWords(8'h31);
    checkOutput("err_sticky", err, 1);
    applyStimulus(1'b1);
    checkOutput("err_cleared", err, 0);
    abortReq = 1'b1;
    tick();
    abortReq = 1'b0;
    checkOutput("err_abort_idle", busy, 0);

    $display("[TB] reset mid-read");
    readWords(8'h31);
    applyStimulus(1'b0);
    rdReady = 1'b1;
    tick();
    tick();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_en", configEn, 0);
    checkOutput("arst_rd_valid", rdValid, 0);
    #2;
    rstN = 1'b1;
    rdReady = 1'b0;
    tick();
    checkOutput("arst_state", dut.r_state, ST_IDLE);
    checkOutput("arst_count", dut.r_count, 0);
    checkOutput("arst_done", done, 0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
